collision_detector: RTL and testbench

- Per-frame hit detector between the player sprite and one obstacle or coin sprite.
- Fires when the player's lane matches any lane the obstacle occupies and their vertical offsets are within a tolerance.
- Outputs a running hit count (score for coins, death flag for trees/rocks) and a one-cycle despawn pulse that feeds back to the spawner.
- Clocked by the frame strobe (vsync) in the top level, so one clock = one frame.

---
 rtl/collision_detector_if.sv | 36 +++
 rtl/collision_detector.sv | 110 +++++++++++
 tb/tb_collision_detector.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/collision_detector_if.sv
// ---------------------------------------------------------------------------
// Module   : collision_detector_if
// Purpose  : Player/obstacle position bundle and hit outputs of collision_detector.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface collision_detector_if #(
  parameter int HWIDTH      = 12,
  parameter int VWIDTH      = 12,
  parameter int OBST_LANE   = 1,
  parameter int COUNT_WIDTH = 32
);
  logic signed [HWIDTH-1:0] player_hoffset;
  logic signed [VWIDTH-1:0] player_voffset;
  logic        [1:0]        player_lane;
  logic signed [HWIDTH-1:0] obst_hoffset;
  logic signed [VWIDTH-1:0] obst_voffset;
  logic        [1:0]        obst_lane [OBST_LANE];
  logic [COUNT_WIDTH-1:0]   count;
  logic                     despawn;

  modport master (
    output player_hoffset, player_voffset, player_lane,
    output obst_hoffset, obst_voffset, obst_lane,
    input  count, despawn
  );

  modport slave (
    input  player_hoffset, player_voffset, player_lane,
    input  obst_hoffset, obst_voffset, obst_lane,
    output count, despawn
  );
endinterface

`default_nettype wire

// File: rtl/collision_detector.sv
// ---------------------------------------------------------------------------
// Module   : collision_detector
// Purpose  : Per-frame player/sprite hit detector with saturating hit count
//            and one-frame despawn pulse. Optional macro COLLISION_HCHECK_EN
//            adds a horizontal distance check.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module collision_detector #(
  parameter int HWIDTH       = 12,
  parameter int VWIDTH       = 12,
  parameter int POS_MISMATCH = 40,
  parameter int OBST_LANE    = 1,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  collision_detector_if.slave bus
);

  localparam int VW_EXT = VWIDTH + 1;
  localparam logic [VWIDTH:0] V_TOL = VW_EXT'(POS_MISMATCH);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  logic [OBST_LANE-1:0]    lane_hit;
  logic                    lane_match;
  logic signed [VWIDTH:0]  pv_ext;
  logic signed [VWIDTH:0]  ov_ext;
  logic signed [VWIDTH:0]  dv_diff;
  logic        [VWIDTH:0]  dv_abs;
  logic                    near_v;
  logic                    near_h;
  logic                    near;
  logic                    hit;
  logic                    hit_event;

  logic                    hit_prev_d, hit_prev_q;
  logic [COUNT_WIDTH-1:0]  count_d, count_q;
  logic                    despawn_d, despawn_q;

  // Lane 3 is the "no lane" code and must never match, even against itself.
  for (genvar gi = 0; gi < OBST_LANE; gi++) begin : g_lane
    assign lane_hit[gi] = (bus.player_lane != 2'd3) &&
                          (bus.obst_lane[gi] == bus.player_lane);
  end

  assign lane_match = |lane_hit;

  // One extra bit keeps the difference exact at the extremes of the range.
  assign pv_ext  = {bus.player_voffset[VWIDTH-1], bus.player_voffset};
  assign ov_ext  = {bus.obst_voffset[VWIDTH-1], bus.obst_voffset};
  assign dv_diff = ov_ext - pv_ext;
  assign dv_abs  = dv_diff[VWIDTH] ? $unsigned(-dv_diff) : $unsigned(dv_diff);
  assign near_v  = (dv_abs <= V_TOL);

`ifdef COLLISION_HCHECK_EN
  localparam int HW_EXT = HWIDTH + 1;
  localparam logic [HWIDTH:0] H_TOL = HW_EXT'(POS_MISMATCH);

  logic signed [HWIDTH:0] ph_ext;
  logic signed [HWIDTH:0] oh_ext;
  logic signed [HWIDTH:0] dh_diff;
  logic        [HWIDTH:0] dh_abs;

  assign ph_ext  = {bus.player_hoffset[HWIDTH-1], bus.player_hoffset};
  assign oh_ext  = {bus.obst_hoffset[HWIDTH-1], bus.obst_hoffset};
  assign dh_diff = oh_ext - ph_ext;
  assign dh_abs  = dh_diff[HWIDTH] ? $unsigned(-dh_diff) : $unsigned(dh_diff);
  assign near_h  = (dh_abs <= H_TOL);
`else
  logic [2*HWIDTH-1:0] unused_hoffsets;

  assign unused_hoffsets = {bus.player_hoffset, bus.obst_hoffset};
  assign near_h          = 1'b1;
`endif

  assign near = near_v & near_h;
  assign hit  = lane_match & near;

  always_comb begin
    hit_prev_d = hit;
    hit_event  = hit & ~hit_prev_q;
    count_d    = count_q;
    despawn_d  = hit_event;
    // Saturate rather than wrap so a long run never reports a tiny score.
    if (hit_event && (count_q != COUNT_MAX)) begin
      count_d = count_q + COUNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_prev_q <= 1'b0;
      count_q    <= '0;
      despawn_q  <= 1'b0;
    end else begin
      hit_prev_q <= hit_prev_d;
      count_q    <= count_d;
      despawn_q  <= despawn_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.despawn = despawn_q;

endmodule

`default_nettype wire

// File: tb/tb_collision_detector.sv
// ---------------------------------------------------------------------------
// Module   : tb_collision_detector
// Purpose  : Directed-vector scoreboard bench for collision_detector.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_collision_detector;

  localparam int HW = 12;
  localparam int VW = 12;
  localparam int PM = 70;
  localparam int NL = 2;
  localparam int CW = 3;

  typedef struct {
    int          tag;
    logic [CW-1:0] count;
    logic        despawn;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;
  int   vec_no;

  collision_detector_if #(
    .HWIDTH(HW), .VWIDTH(VW), .OBST_LANE(NL), .COUNT_WIDTH(CW)
  ) bus ();

  collision_detector #(
    .HWIDTH(HW), .VWIDTH(VW), .POS_MISMATCH(PM),
    .OBST_LANE(NL), .COUNT_WIDTH(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one frame of inputs, then queue the outputs expected after the edge.
  task automatic step(input logic rn, input int plane, input int pv, input int ov,
                      input int l0, input int l1, input int ph, input int oh,
                      input int ecount, input int edesp);
    exp_t e;
    @(negedge clk);
    rst_n              = rn;
    bus.player_lane    = 2'(plane);
    bus.player_voffset = VW'(pv);
    bus.obst_voffset   = VW'(ov);
    bus.obst_lane[0]   = 2'(l0);
    bus.obst_lane[1]   = 2'(l1);
    bus.player_hoffset = HW'(ph);
    bus.obst_hoffset   = HW'(oh);
    @(posedge clk);
    e.tag     = vec_no;
    e.count   = CW'(ecount);
    e.despawn = edesp[0];
    exp_q.push_back(e);
    vec_no++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (bus.count !== e.count) begin
        n_errors++;
        $display("FAIL count vec%0d: got %0d expected %0d", e.tag, bus.count, e.count);
      end
      n_checks++;
      if (bus.despawn !== e.despawn) begin
        n_errors++;
        $display("FAIL despawn vec%0d: got %0b expected %0b", e.tag, bus.despawn, e.despawn);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    vec_no   = 0;
    rst_n    = 1'b0;
    bus.player_lane    = 2'd0;
    bus.player_voffset = '0;
    bus.obst_voffset   = '0;
    bus.obst_lane[0]   = 2'd3;
    bus.obst_lane[1]   = 2'd3;
    bus.player_hoffset = '0;
    bus.obst_hoffset   = '0;

    // Reset held with a hit present, then first event on release
    step(0, 1, 50, 50, 1, 1, 0, 0, 0, 0);
    step(0, 1, 50, 50, 1, 1, 0, 0, 0, 0);
    step(1, 1, 50, 50, 1, 1, 0, 0, 1, 1);
    step(1, 1, 50, 50, 1, 1, 0, 0, 1, 0);

    // Coin pass, player at 50 in lane 1
    step(0, 1, 50, -140, 1, 1, 0, 0, 0, 0);
    step(1, 1, 50, -140, 1, 1, 0, 0, 0, 0);
    step(1, 1, 50, -108, 1, 1, 0, 0, 0, 0);
    step(1, 1, 50,  -76, 1, 1, 0, 0, 0, 0);
    step(1, 1, 50,  -44, 1, 1, 0, 0, 0, 0);
    step(1, 1, 50,  -18, 1, 1, 0, 0, 1, 1);
    step(1, 1, 50,   14, 1, 1, 0, 0, 1, 0);
    step(1, 1, 50,   46, 1, 1, 0, 0, 1, 0);
    step(1, 1, 50,  110, 1, 1, 0, 0, 1, 0);
    step(1, 1, 50,  121, 1, 1, 0, 0, 1, 0);
    step(1, 1, 50,  220, 1, 1, 0, 0, 1, 0);

    // Lane mismatch and the never-matching lane 3
    step(0, 0, 50,  50, 1, 1, 0, 0, 0, 0);
    step(1, 0, 50,  50, 1, 1, 0, 0, 0, 0);
    step(1, 0, 50, -18, 1, 1, 0, 0, 0, 0);
    step(1, 3, 50,  50, 3, 3, 0, 0, 0, 0);
    step(1, 3, 50,  50, 1, 2, 0, 0, 0, 0);

    // Two-lane tree: lane change inside the set, then out and back
    step(0, 2, 50, 50, 1, 2, 0, 0, 0, 0);
    step(1, 2, 50, 50, 1, 2, 0, 0, 1, 1);
    step(1, 1, 50, 50, 1, 2, 0, 0, 1, 0);
    step(1, 0, 50, 50, 1, 2, 0, 0, 1, 0);
    step(1, 1, 50, 50, 1, 2, 0, 0, 2, 1);
    step(1, 2, 50, 50, 1, 2, 0, 0, 2, 0);

    // Tolerance edges and extreme offsets
    step(0, 1,     0,    0, 1, 2, 0, 0, 0, 0);
    step(1, 1,     0,   70, 1, 2, 0, 0, 1, 1);
    step(1, 1,     0,   71, 1, 2, 0, 0, 1, 0);
    step(1, 1,     0,  -70, 1, 2, 0, 0, 2, 1);
    step(1, 1,     0,  -71, 1, 2, 0, 0, 2, 0);
    step(1, 1, -2048, 2047, 1, 2, 0, 0, 2, 0);
    step(1, 1,  2047,-2048, 1, 2, 0, 0, 2, 0);

    // Saturation: alternate hit/miss, count pins at 7 but despawn keeps pulsing
    step(1, 1, 0,   0, 1, 2, 0, 0, 3, 1);
    step(1, 1, 0, 200, 1, 2, 0, 0, 3, 0);
    step(1, 1, 0,   0, 1, 2, 0, 0, 4, 1);
    step(1, 1, 0, 200, 1, 2, 0, 0, 4, 0);
    step(1, 1, 0,   0, 1, 2, 0, 0, 5, 1);
    step(1, 1, 0, 200, 1, 2, 0, 0, 5, 0);
    step(1, 1, 0,   0, 1, 2, 0, 0, 6, 1);
    step(1, 1, 0, 200, 1, 2, 0, 0, 6, 0);
    step(1, 1, 0,   0, 1, 2, 0, 0, 7, 1);
    step(1, 1, 0, 200, 1, 2, 0, 0, 7, 0);
    step(1, 1, 0,   0, 1, 2, 0, 0, 7, 1);
    step(1, 1, 0,   0, 1, 2, 0, 0, 7, 0);
    step(1, 1, 0, 200, 1, 2, 0, 0, 7, 0);
    step(1, 1, 0,   0, 1, 2, 0, 0, 7, 1);

    // Reset wins over a simultaneous hit
    step(0, 1, 0, 0, 1, 2, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 2, 0, 0, 1, 1);

    // Horizontal distance: only gates hits when the check is built in
    step(0, 1, 0, 200, 1, 2, 0,    0, 0, 0);
`ifdef COLLISION_HCHECK_EN
    step(1, 1, 0,   0, 1, 2, 0,  100, 0, 0);
    step(1, 1, 0,   0, 1, 2, 0,   70, 1, 1);
    step(1, 1, 0,   0, 1, 2, 0, -100, 1, 0);
    step(1, 1, 0,   0, 1, 2, 0,  -70, 2, 1);
    step(1, 1, 0,   0, 1, 2, 0,   71, 2, 0);
`else
    step(1, 1, 0,   0, 1, 2, 0,  100, 1, 1);
    step(1, 1, 0,   0, 1, 2, 0,   70, 1, 0);
    step(1, 1, 0,   0, 1, 2, 0, -100, 1, 0);
    step(1, 1, 0,   0, 1, 2, 0,  -70, 1, 0);
    step(1, 1, 0,   0, 1, 2, 0,   71, 1, 0);
`endif

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
